wshb_fb_slave: RTL and testbench

//  Wishbone B4 slave that answers master writes and reads into an on-chip pixel word memory.

---
 rtl/wshb_slave_pkg.sv | 20 ++
 rtl/wshb_if.sv | 33 +++
 rtl/wshb_fb_slave_ram.sv | 33 +++
 rtl/wshb_fb_slave.sv | 182 ++++++++++++++++++
 tb/tb_wshb_fb_slave.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wshb_slave_pkg.sv
// Shared types for the Wishbone framebuffer slave.
// Cycle-type tags, burst-type tags and FSM states.
package wshb_slave_pkg;

  typedef logic [2:0] cti_t;
  typedef logic [1:0] bte_t;

  localparam cti_t CTI_CLASSIC = 3'b000;
  localparam cti_t CTI_INCR    = 3'b010;
  localparam cti_t CTI_EOB     = 3'b111;
  localparam bte_t BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    BURST
  } state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle between a master and the
// framebuffer slave.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;

  modport slave (
    input  clk, rst, cyc, stb, we, adr,
    input  sel, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output cyc, stb, we, adr, sel, dat_ms,
    output cti, bte
  );

endinterface

// File: rtl/wshb_fb_slave_ram.sv
// Single-port pixel word RAM, byte enables,
// read-first registered output, no reset.
module fb_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem[addr];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wshb_fb_slave.sv
// Wishbone B4 slave over on-chip pixel memory with
// wait-state insertion and incrementing-burst prefetch.
module wshb_fb_slave
  import wshb_slave_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  wshb_if.slave wshb_ifs
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD =
    4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  localparam logic [AW:0] ONE = 1;

  logic          clk;
  logic          rst;
  logic          req;
  logic          oor;
  logic [AW-1:0] word_adr;
  logic [AW:0]   inc_adr;
  logic          ack_vis;
  logic          err_vis;
  logic          unused_adr;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [AW:0]   nxt_q, nxt_d;
  logic [31:0]   dat_q, dat_d;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  assign clk        = wshb_ifs.clk;
  assign rst        = wshb_ifs.rst;
  assign req        = wshb_ifs.cyc & wshb_ifs.stb;
  assign word_adr   = wshb_ifs.adr[AW+1:2];
  assign oor        = |wshb_ifs.adr[31:AW+2];
  assign unused_adr = ^wshb_ifs.adr[1:0];
  assign ack_vis    = ack_q & req;
  assign err_vis    = err_q & req;

  // Bit AW set means the next burst word fell off the end.
  assign inc_adr = (state_q == BURST)
                 ? nxt_q + ONE
                 : {1'b0, word_adr} + ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    err_d    = err_q;
    nxt_d    = nxt_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = word_adr;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = ACK;
            ack_d   = ~oor;
            err_d   = oor;
            ram_en  = ~oor;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack_d   = ~oor;
          err_d   = oor;
          ram_en  = ~oor;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        ram_we = ack_vis & wshb_ifs.we;
        ram_en = ram_we;
        if (ack_vis &&
            wshb_ifs.cti == CTI_INCR &&
            wshb_ifs.bte == BTE_LINEAR) begin
          state_d = BURST;
          nxt_d   = inc_adr;
          ack_d   = ~inc_adr[AW];
          err_d   = inc_adr[AW];
          if (!wshb_ifs.we) begin
            ram_en   = ~inc_adr[AW];
            ram_addr = inc_adr[AW-1:0];
          end
        end else begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      BURST: begin
        if (!wshb_ifs.cyc) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end else if (ack_vis || err_vis) begin
          ram_we   = ack_vis & wshb_ifs.we;
          ram_en   = ram_we;
          ram_addr = nxt_q[AW-1:0];
          if (err_vis || wshb_ifs.cti == CTI_EOB) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
          end else begin
            nxt_d = inc_adr;
            ack_d = ~inc_adr[AW];
            err_d = inc_adr[AW];
            if (!wshb_ifs.we) begin
              ram_en   = ~inc_adr[AW];
              ram_addr = inc_adr[AW-1:0];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dat_d = dat_q;
    if (err_vis) begin
      dat_d = '0;
    end else if (ack_vis && !wshb_ifs.we) begin
      dat_d = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      nxt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      nxt_q   <= nxt_d;
      dat_q   <= dat_d;
    end
  end

  fb_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en & ~rst),
    .we    (ram_we & ~rst),
    .addr  (ram_addr),
    .be    (wshb_ifs.sel),
    .wdata (wshb_ifs.dat_ms),
    .rdata (ram_rdata)
  );

  assign wshb_ifs.ack    = ack_vis;
  assign wshb_ifs.err    = err_vis;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = dat_d;

endmodule

// File: tb/tb_wshb_fb_slave.sv
// Scoreboard bench for wshb_fb_slave: one instance with
// no wait states, one with three.
module tb_wshb_fb_slave;
  import wshb_slave_pkg::*;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc_cnt  = 0;

  exp_t q0[$];
  exp_t q3[$];

  logic [31:0] mdat [8] = '{
    32'h0000_0001, 32'h1234_5678, 32'hCAFE_BABE,
    32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
    32'h8000_0000, 32'h7FFF_FFFF
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wshb_if b0 (.clk(clk), .rst(rst));
  wshb_if b3 (.clk(clk), .rst(rst));

  wshb_fb_slave #(
    .DEPTH(1024), .WAIT_CYCLES(0)
  ) u0 (
    .wshb_ifs(b0)
  );

  wshb_fb_slave #(
    .DEPTH(1024), .WAIT_CYCLES(3)
  ) u3 (
    .wshb_ifs(b3)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  function automatic exp_t mk(input logic e,
                              input logic c,
                              input logic [31:0] d);
    exp_t x;
    x.err = e;
    x.chk = c;
    x.dat = d;
    return x;
  endfunction

  // Scoreboard monitors: pop on every visible termination.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (b0.ack === 1'b1 || b0.err === 1'b1)) begin
      if (q0.size() == 0) begin
        chk("term0_unexpected", {b0.ack, b0.err}, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("term0", {30'd0, b0.ack, b0.err},
            e.err ? 32'd1 : 32'd2);
        if (e.err || e.chk) chk("dat0", b0.dat_sm, e.dat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (b3.ack === 1'b1 || b3.err === 1'b1)) begin
      if (q3.size() == 0) begin
        chk("term3_unexpected", {b3.ack, b3.err}, 32'd0);
      end else begin
        e = q3.pop_front();
        chk("term3", {30'd0, b3.ack, b3.err},
            e.err ? 32'd1 : 32'd2);
        if (e.err || e.chk) chk("dat3", b3.dat_sm, e.dat);
      end
    end
  end

  task automatic drop0;
    b0.cyc = 1'b0;
    b0.stb = 1'b0;
    b0.we  = 1'b0;
    b0.cti = CTI_CLASSIC;
  endtask

  task automatic classic(input string nm,
                         input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    b0.cyc = 1'b1; b0.stb = 1'b1; b0.we = w;
    b0.adr = a; b0.dat_ms = d; b0.sel = s;
    b0.cti = CTI_CLASSIC; b0.bte = BTE_LINEAR;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b0.ack === 1'b1 || b0.err === 1'b1) && n < 30);
    chk(nm, n, 2);
    @(posedge clk); #1;
    drop0();
  endtask

  task automatic burst(input logic w,
                       input logic [31:0] a0,
                       input int n,
                       input logic [31:0] wd [4],
                       input int stall_at,
                       output int t [4]);
    int b;
    int nw;
    logic terr;
    bit done;
    for (int i = 0; i < 4; i++) t[i] = 0;
    @(posedge clk); #1;
    b0.cyc = 1'b1; b0.stb = 1'b1; b0.we = w;
    b0.adr = a0; b0.dat_ms = wd[0]; b0.sel = 4'hF;
    b0.bte = BTE_LINEAR;
    b0.cti = (n == 1) ? CTI_EOB : CTI_INCR;
    b = 0; nw = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      nw++;
      if (b0.ack === 1'b1 || b0.err === 1'b1) begin
        t[b] = cyc_cnt;
        terr = b0.err;
        b++;
        nw = 0;
        @(posedge clk); #1;
        if (b >= n || terr) begin
          drop0();
          done = 1'b1;
        end else begin
          b0.adr    = a0 + 32'(4 * b);
          b0.dat_ms = wd[b];
          b0.cti    = (b == n - 1) ? CTI_EOB : CTI_INCR;
          if (b == stall_at) begin
            b0.stb = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            b0.stb = 1'b1;
          end
        end
      end else if (nw >= 20) begin
        chk("burst_timeout", 32'(b), 32'(n));
        drop0();
        done = 1'b1;
      end
    end
  endtask

  // Stb held high across all eight transfers.
  task automatic mire(input logic w);
    int n;
    @(posedge clk); #1;
    b3.cyc = 1'b1; b3.stb = 1'b1; b3.we = w;
    b3.adr = 32'h40; b3.dat_ms = mdat[0];
    b3.sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (b3.ack !== 1'b1 && n < 30);
      chk(w ? "mire_wr_lat" : "mire_rd_lat", n, 5);
      @(posedge clk); #1;
      if (i < 7) begin
        b3.adr    = 32'h40 + 32'(4 * (i + 1));
        b3.dat_ms = mdat[i + 1];
      end else begin
        b3.cyc = 1'b0;
        b3.stb = 1'b0;
        b3.we  = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    int t [4];
    logic [31:0] wd [4];
    logic [31:0] zd [4];

    for (int i = 0; i < 4; i++) zd[i] = '0;

    b3.cyc = 1'b0; b3.stb = 1'b0; b3.we = 1'b0;
    b3.adr = '0; b3.sel = 4'hF; b3.dat_ms = '0;
    b3.cti = CTI_CLASSIC; b3.bte = BTE_LINEAR;

    // Reset with a pending write to word 0.
    b0.cyc = 1'b1; b0.stb = 1'b1; b0.we = 1'b1;
    b0.adr = 32'h0; b0.sel = 4'hF;
    b0.dat_ms = 32'h5A5A_5A5A;
    b0.cti = CTI_CLASSIC; b0.bte = BTE_LINEAR;
    q0.push_back(mk(1'b0, 1'b0, 32'h0));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_term", {b0.ack, b0.err}, 32'd0);
      chk("rst_dat", b0.dat_sm, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b0.ack !== 1'b1 && n < 30);
    chk("rst_first_ack", n, 2);
    @(posedge clk); #1;
    drop0();

    // Classic write then read.
    q0.push_back(mk(1'b0, 1'b0, 32'h0));
    classic("wr_lat", 1'b1, 32'h10, 32'hA1B2_C3D4, 4'hF);
    q0.push_back(mk(1'b0, 1'b1, 32'hA1B2_C3D4));
    classic("rd_lat", 1'b0, 32'h10, 32'h0, 4'hF);

    // Byte enables.
    q0.push_back(mk(1'b0, 1'b0, 32'h0));
    classic("be_wr1", 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF);
    q0.push_back(mk(1'b0, 1'b0, 32'h0));
    classic("be_wr2", 1'b1, 32'h14, 32'h0, 4'b0101);
    q0.push_back(mk(1'b0, 1'b1, 32'hFF00_FF00));
    classic("be_rd", 1'b0, 32'h14, 32'h0, 4'hF);

    // Wait-state instance, writes then readback.
    for (int i = 0; i < 8; i++)
      q3.push_back(mk(1'b0, 1'b0, 32'h0));
    mire(1'b1);
    for (int i = 0; i < 8; i++)
      q3.push_back(mk(1'b0, 1'b1, mdat[i]));
    mire(1'b0);

    // Burst read over 1,2,3,4 with a 2-cycle stall.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 1'b0, 32'h0));
      classic("pre_wr", 1'b1, 32'h20 + 32'(4 * i),
              32'(i + 1), 4'hF);
    end
    for (int i = 0; i < 4; i++)
      q0.push_back(mk(1'b0, 1'b1, 32'(i + 1)));
    burst(1'b0, 32'h20, 4, zd, 2, t);
    chk("burst_gap01", 32'(t[1] - t[0]), 32'd1);
    chk("burst_gap12", 32'(t[2] - t[1]), 32'd3);
    chk("burst_gap23", 32'(t[3] - t[2]), 32'd1);

    // Out of range classic read and write.
    q0.push_back(mk(1'b1, 1'b1, 32'h0));
    classic("oor_rd", 1'b0, 32'h1000, 32'h0, 4'hF);
    q0.push_back(mk(1'b1, 1'b1, 32'h0));
    classic("oor_wr", 1'b1, 32'h1000, 32'hBAD0_BAD0, 4'hF);

    // Write burst crossing the last word.
    wd[0] = 32'h11; wd[1] = 32'h22;
    wd[2] = 32'h33; wd[3] = 32'h44;
    q0.push_back(mk(1'b0, 1'b0, 32'h0));
    q0.push_back(mk(1'b0, 1'b0, 32'h0));
    q0.push_back(mk(1'b1, 1'b1, 32'h0));
    burst(1'b1, 32'hFF8, 3, wd, -1, t);
    chk("cross_gap", 32'(t[2] - t[0]), 32'd2);

    q0.push_back(mk(1'b0, 1'b1, 32'h5A5A_5A5A));
    classic("w0_rd", 1'b0, 32'h0, 32'h0, 4'hF);
    q0.push_back(mk(1'b0, 1'b1, 32'h11));
    classic("w1022_rd", 1'b0, 32'hFF8, 32'h0, 4'hF);
    q0.push_back(mk(1'b0, 1'b1, 32'h22));
    classic("w1023_rd", 1'b0, 32'hFFC, 32'h0, 4'hF);

    repeat (4) @(posedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
